// File: rtl/seg7_capture_fifo_pkg.sv
// Shared 7-segment definitions: bus widths and the gfedcba pattern for each hex digit.
// Imported by the capture FIFO and its decoder.
package seg7_capture_fifo_pkg;
  localparam int SEG_W   = 7;
  localparam int DIGIT_W = 4;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_0 = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_A = 7'b1110111;
  localparam logic [SEG_W-1:0] SEG_B = 7'b1111100;
  localparam logic [SEG_W-1:0] SEG_C = 7'b0111001;
  localparam logic [SEG_W-1:0] SEG_D = 7'b1011110;
  localparam logic [SEG_W-1:0] SEG_E = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_F = 7'b1110001;
endpackage

// File: rtl/seg7_capture_fifo_decode.sv
// Combinational 7-segment to hex decoder; hit is low for blank and any non-digit pattern.
module seg7_decode
  import seg7_capture_fifo_pkg::*;
(
  input  logic [SEG_W-1:0]   pattern,
  output logic               hit,
  output logic [DIGIT_W-1:0] digit
);
  always_comb begin
    hit   = 1'b1;
    digit = 4'h0;
    case (pattern)
      SEG_0:   digit = 4'h0;
      SEG_1:   digit = 4'h1;
      SEG_2:   digit = 4'h2;
      SEG_3:   digit = 4'h3;
      SEG_4:   digit = 4'h4;
      SEG_5:   digit = 4'h5;
      SEG_6:   digit = 4'h6;
      SEG_7:   digit = 4'h7;
      SEG_8:   digit = 4'h8;
      SEG_9:   digit = 4'h9;
      SEG_A:   digit = 4'hA;
      SEG_B:   digit = 4'hB;
      SEG_C:   digit = 4'hC;
      SEG_D:   digit = 4'hD;
      SEG_E:   digit = 4'hE;
      SEG_F:   digit = 4'hF;
      default: hit = 1'b0;
    endcase
  end
endmodule

// File: rtl/seg7_capture_fifo.sv
// Samples a 7-segment bus, captures patterns that hold steady, decodes them and queues digits
// in a FWFT FIFO. Define SEG7_ERR_EN to add err_pulse/err_cnt reporting of invalid patterns.
module seg7_capture_fifo
  import seg7_capture_fifo_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int DEPTH         = 8,
  localparam int CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SEG_W-1:0]   segments,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [DIGIT_W-1:0] out_digit,
  output logic [CNT_W-1:0]   level,
  output logic               full,
`ifdef SEG7_ERR_EN
  output logic               err_pulse,
  output logic [7:0]         err_cnt,
`endif
  output logic               overflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int STB_W = $clog2(STABLE_CYCLES + 1);

  logic [SEG_W-1:0]   s1_q, s2_q, last_q;
  logic [STB_W-1:0]   stb_q, stb_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   level_q, level_d;
  logic               overflow_q;
  logic [DIGIT_W-1:0] mem_q [DEPTH];

  logic               hit, capture, push_req, push_ok, pop, empty;
  logic [DIGIT_W-1:0] dec_digit;

  seg7_decode u_decode (
    .pattern (s2_q),
    .hit     (hit),
    .digit   (dec_digit)
  );

  // s1 != s2 means s2 changes at the coming edge, so the count restarts in step with it
  always_comb begin
    stb_d = stb_q;
    if (s1_q != s2_q)
      stb_d = '0;
    else if (stb_q != STB_W'(STABLE_CYCLES))
      stb_d = stb_q + 1'b1;
  end

  assign capture  = (stb_q == STB_W'(STABLE_CYCLES)) && (s2_q != last_q);
  assign push_req = capture && hit;
  assign empty    = (level_q == '0);
  assign full     = (level_q == CNT_W'(DEPTH));
  assign pop      = !empty && out_ready;
  // When full, a same-cycle pop frees the slot the push lands in
  assign push_ok  = push_req && (!full || pop);

  always_comb begin
    level_d = level_q;
    if (push_ok && !pop)
      level_d = level_q + 1'b1;
    else if (!push_ok && pop)
      level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q       <= SEG_BLANK;
      s2_q       <= SEG_BLANK;
      last_q     <= SEG_BLANK;
      stb_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      s1_q    <= segments;
      s2_q    <= s1_q;
      stb_q   <= stb_d;
      level_q <= level_d;
      if (capture)
        last_q <= s2_q;
      if (push_ok)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_req && !push_ok)
        overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wr_ptr_q] <= dec_digit;
  end

  assign out_valid = !empty;
  assign out_digit = empty ? '0 : mem_q[rd_ptr_q];
  assign level     = level_q;
  assign overflow  = overflow_q;

`ifdef SEG7_ERR_EN
  logic [7:0] err_cnt_q;

  assign err_pulse = capture && !hit && (s2_q != SEG_BLANK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      err_cnt_q <= '0;
    else if (err_pulse && (err_cnt_q != 8'hFF))
      err_cnt_q <= err_cnt_q + 1'b1;
  end

  assign err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_seg7_capture_fifo.sv
// Directed bench for seg7_capture_fifo: vector table for push/pop sequences plus
// hand-written latency, overflow, full push+pop and async reset sequences.
module tb_seg7_capture_fifo;
  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] segments;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_digit;
  logic [3:0] level;
  logic       full;
  logic       overflow;
`ifdef SEG7_ERR_EN
  logic       err_pulse;
  logic [7:0] err_cnt;
  int         pulse_seen = 0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  seg7_capture_fifo #(.STABLE_CYCLES(4), .DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .segments  (segments),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_digit (out_digit),
    .level     (level),
    .full      (full),
`ifdef SEG7_ERR_EN
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
`endif
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

`ifdef SEG7_ERR_EN
  always @(negedge clk) if (reset && err_pulse) pulse_seen++;
`endif

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else
      $display("ok   %s: %0d", name, act);
  endtask

  typedef struct {
    logic [6:0] seg;
    logic       rdy;
    int         cyc;
    int         lvl;
    int         dig;
  } vec_t;

  vec_t       tbl[18];
  logic [6:0] pats[16];

  initial begin
    tbl[0]  = '{7'b0000110, 1'b0, 8, 1, 1};
    tbl[1]  = '{7'b1011011, 1'b0, 8, 2, 1};
    tbl[2]  = '{7'b1001111, 1'b0, 8, 3, 1};
    tbl[3]  = '{7'b0000110, 1'b0, 8, 4, 1};
    tbl[4]  = '{7'b1111111, 1'b0, 2, 4, 1};
    tbl[5]  = '{7'b0000110, 1'b0, 8, 4, 1};
    tbl[6]  = '{7'b1101101, 1'b0, 8, 5, 1};
    tbl[7]  = '{7'b0000000, 1'b0, 6, 5, 1};
    tbl[8]  = '{7'b1101101, 1'b0, 8, 6, 1};
    tbl[9]  = '{7'b1101101, 1'b0, 8, 6, 1};
    tbl[10] = '{7'b0000001, 1'b0, 8, 6, 1};
    tbl[11] = '{7'b0000000, 1'b0, 8, 6, 1};
    tbl[12] = '{7'b0000000, 1'b1, 1, 5, 2};
    tbl[13] = '{7'b0000000, 1'b1, 1, 4, 3};
    tbl[14] = '{7'b0000000, 1'b1, 1, 3, 1};
    tbl[15] = '{7'b0000000, 1'b1, 1, 2, 5};
    tbl[16] = '{7'b0000000, 1'b1, 1, 1, 5};
    tbl[17] = '{7'b0000000, 1'b1, 1, 0, 0};

    pats[0]  = 7'b0111111; pats[1]  = 7'b0000110; pats[2]  = 7'b1011011; pats[3]  = 7'b1001111;
    pats[4]  = 7'b1100110; pats[5]  = 7'b1101101; pats[6]  = 7'b1111101; pats[7]  = 7'b0000111;
    pats[8]  = 7'b1111111; pats[9]  = 7'b1101111; pats[10] = 7'b1110111; pats[11] = 7'b1111100;
    pats[12] = 7'b0111001; pats[13] = 7'b1011110; pats[14] = 7'b1111001; pats[15] = 7'b1110001;

    reset = 1'b0;
    segments = 7'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_level", level, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_digit", out_digit, 0);
    chk("reset_full", full, 0);
    chk("reset_overflow", overflow, 0);
    reset = 1'b1;

    // Latency: valid must be low after E5 and high after E6
    segments = pats[0];
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) chk("lat_valid_E5", out_valid, 0);
      if (k == 7) chk("lat_valid_E6", out_valid, 1);
    end
    repeat (3) @(negedge clk);
    chk("hold0_level", level, 1);
    chk("hold0_digit", out_digit, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold0_popped_level", level, 0);
    chk("hold0_popped_valid", out_valid, 0);

    for (int i = 0; i < 18; i++) begin
      segments = tbl[i].seg;
      out_ready = tbl[i].rdy;
      repeat (tbl[i].cyc) @(negedge clk);
      chk($sformatf("vec%0d_level", i), level, tbl[i].lvl);
      chk($sformatf("vec%0d_digit", i), out_digit, tbl[i].dig);
      chk($sformatf("vec%0d_valid", i), out_valid, tbl[i].lvl != 0);
    end
    out_ready = 1'b0;
`ifdef SEG7_ERR_EN
    chk("err_cnt", err_cnt, 1);
    chk("err_pulses", pulse_seen, 1);
`endif
    chk("no_overflow_yet", overflow, 0);

    // Ten distinct digits into an 8-deep FIFO
    for (int i = 0; i < 10; i++) begin
      segments = pats[i];
      repeat (8) @(negedge clk);
    end
    chk("ovf_level", level, 8);
    chk("ovf_full", full, 1);
    chk("ovf_overflow", overflow, 1);
    chk("ovf_head", out_digit, 0);

    // Push of A lands on the same edge as a pop while full
    segments = pats[10];
    repeat (6) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("pushpop_level", level, 8);
    chk("pushpop_full", full, 1);
    chk("pushpop_head", out_digit, 1);
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("drain_head%0d", i), out_digit, i);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    chk("drain_level", level, 3);
    chk("drain_head6", out_digit, 6);

    // Asynchronous reset between clock edges
    #3 reset = 1'b0;
    #1;
    chk("areset_level", level, 0);
    chk("areset_valid", out_valid, 0);
    chk("areset_digit", out_digit, 0);
    chk("areset_full", full, 0);
    chk("areset_overflow", overflow, 0);
`ifdef SEG7_ERR_EN
    chk("areset_err_cnt", err_cnt, 0);
`endif
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_reset_level", level, 1);
    chk("post_reset_digit", out_digit, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
